alu_cmd_sequencer: RTL and testbench

//  Initiator side of the 4-bit ALU operation interface. Buffers operation commands arriving on a

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_cmd_fifo.sv | 31 +++
 rtl/alu_cmd_sequencer.sv | 103 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, default datapath width and sequencer FSM states
package alu_pkg;
   localparam int ALU_DATA_W = 4;
   localparam logic [2:0] ALU_NOP  = 3'd0;
   localparam logic [2:0] ALU_AND  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_PASS = 3'd3;
   localparam logic [2:0] ALU_ADD  = 3'd4;
   localparam logic [2:0] ALU_SUB  = 3'd5;
   localparam logic [2:0] ALU_SHR  = 3'd6;
   localparam logic [2:0] ALU_SHL  = 3'd7;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} seq_state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO; pointers carry a wrap bit to tell full from empty
module alu_cmd_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues them one at a time to a registered ALU,
// waits out its latency and returns result/flags on a valid/ready response channel.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W     = ALU_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int ALU_LAT    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_opcode,
   input  logic [DATA_W-1:0] cmd_src_a,
   input  logic [DATA_W-1:0] cmd_src_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_overflow,
   output logic [2:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_src_a,
   output logic [DATA_W-1:0] alu_src_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   input  logic              clr_stats,
   output logic [7:0]        ovf_count,
   output logic              busy
);
   localparam int EW = 3 + 2 * DATA_W;
   localparam int CW = $clog2(ALU_LAT + 1);
   seq_state_t state, state_nx;
   logic [CW-1:0] wait_cnt;
   logic [EW-1:0] head;
   logic full, empty, push, pop, capture;
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign busy      = !empty || state != ST_IDLE;
   alu_cmd_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({cmd_opcode, cmd_src_a, cmd_src_b}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      capture  = 1'b0;
      case (state)
         ST_IDLE: begin
            pop      = !empty;
            state_nx = empty ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            capture  = wait_cnt == '0;
            state_nx = capture ? ST_RESP : ST_WAIT;
         end
         ST_RESP: begin
            pop      = rsp_ready && !empty;
            state_nx = !rsp_ready ? ST_RESP : empty ? ST_IDLE : ST_WAIT;
         end
         default: state_nx = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         alu_opcode   <= '0;
         alu_src_a    <= '0;
         alu_src_b    <= '0;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         ovf_count    <= '0;
      end else begin
         state <= state_nx;
         if (pop) begin
            {alu_opcode, alu_src_a, alu_src_b} <= head;
            wait_cnt <= CW'(ALU_LAT);
         end else if (state == ST_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (capture) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
         end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         // clear wins over a same-edge overflow capture
         if (clr_stats) ovf_count <= '0;
         else if (capture && alu_overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 1'b1;
      end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: drives the sequencer against a behavioural registered ALU and
// checks responses, timing and the overflow counter against a queue-based reference model.
module tb_alu_cmd_sequencer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic [2:0] cmd_opcode = '0;
   logic [3:0] cmd_src_a = '0, cmd_src_b = '0;
   logic       rsp_valid, rsp_ready = 1'b0;
   logic [3:0] rsp_result;
   logic       rsp_zero, rsp_overflow;
   logic [2:0] alu_opcode;
   logic [3:0] alu_src_a, alu_src_b, alu_result;
   logic       alu_zero, alu_overflow;
   logic       clr_stats = 1'b0;
   logic [7:0] ovf_count;
   logic       busy;

   int n_cmp = 0, n_bad = 0;
   int model_ovf = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DATA_W(4), .FIFO_DEPTH(4), .ALU_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
      .alu_opcode(alu_opcode), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .clr_stats(clr_stats), .ovf_count(ovf_count), .busy(busy)
   );

   // 4-bit ALU reference: returns {overflow, zero, result}
   function automatic logic [5:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int sa, sb, s;
      logic [3:0] r;
      logic v;
      sa = int'(signed'(a));
      sb = int'(signed'(b));
      v = 1'b0;
      s = 0;
      case (op)
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = a;
         3'd4: begin s = sa + sb; r = 4'(s); v = s > 7 || s < -8; end
         3'd5: begin s = sa - sb; r = 4'(s); v = s > 7 || s < -8; end
         3'd6: r = a >> b;
         3'd7: r = a << b;
         default: r = 4'd0;
      endcase
      return {v, r == 4'd0, r};
   endfunction

   always @(posedge clk or negedge reset)
      if (!reset) {alu_overflow, alu_zero, alu_result} <= '0;
      else {alu_overflow, alu_zero, alu_result} <= alu_ref(alu_opcode, alu_src_a, alu_src_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // handshakes are decided by values held stable across the negative edge
   always @(negedge clk)
      if (reset) begin
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back(alu_ref(cmd_opcode, cmd_src_a, cmd_src_b));
            model_ovf = (model_ovf + int'(exp_q[$][5]) > 255) ? 255 : model_ovf + int'(exp_q[$][5]);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
            else check("rsp_data", {26'd0, rsp_overflow, rsp_zero, rsp_result}, {26'd0, exp_q.pop_front()});
         end
      end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic acc;
      cmd_valid = 1'b1; cmd_opcode = op; cmd_src_a = a; cmd_src_b = b;
      for (int i = 0; i < 50; i++) begin
         acc = cmd_ready;
         step();
         if (acc) begin
            cmd_valid = 1'b0;
            return;
         end
      end
      cmd_valid = 1'b0;
      check("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_rsp(input string tag, input logic [3:0] r, input logic z, input logic v);
      for (int i = 0; i < 20 && !rsp_valid; i++) step();
      check(tag, {26'd0, rsp_valid, rsp_overflow, rsp_zero, rsp_result}, {26'd0, 1'b1, v, z, r});
   endtask

   task automatic drain;
      int i;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (i = 0; i < 400 && (busy || rsp_valid || exp_q.size() != 0); i++) step();
      check("drain_idle", {31'd0, busy || rsp_valid || exp_q.size() != 0}, 32'd0);
   endtask

   initial begin
      int accepts, n;
      logic acc;
      #2;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_outputs", {rsp_valid, busy, alu_opcode, alu_src_a, alu_src_b, rsp_result, ovf_count}, 0);
      step(); step();
      reset = 1'b1;
      rsp_ready = 1'b1;
      // single ADD latency
      cmd_valid = 1'b1; cmd_opcode = 3'd4; cmd_src_a = 4'd3; cmd_src_b = 4'd4;
      step();
      cmd_valid = 1'b0;
      check("t1_op_after_e0", alu_opcode, 3'b000);
      step();
      check("t1_op_after_e1", {alu_opcode, alu_src_a, alu_src_b}, {3'b100, 4'd3, 4'd4});
      step();
      check("t1_rsp_low_e2", rsp_valid, 0);
      step();
      check("t1_rsp_e3", {rsp_valid, rsp_overflow, rsp_zero, rsp_result}, {1'b1, 1'b0, 1'b0, 4'd7});
      step();
      // overflow and zero flags
      send(3'd4, 4'd7, 4'd1);
      wait_rsp("t2_add_ovf", 4'b1000, 1'b0, 1'b1);
      step();
      send(3'd5, 4'd4, 4'd4);
      wait_rsp("t2_sub_zero", 4'd0, 1'b1, 1'b0);
      step();
      drain();
      check("t2_ovf_count", ovf_count, 1);
      // fill with the response channel stalled
      rsp_ready = 1'b0;
      accepts = 0;
      cmd_valid = 1'b1; cmd_opcode = 3'($urandom); cmd_src_a = 4'($urandom); cmd_src_b = 4'($urandom);
      for (int i = 0; i < 12; i++) begin
         acc = cmd_ready;
         step();
         if (acc) begin
            accepts++;
            cmd_opcode = 3'($urandom); cmd_src_a = 4'($urandom); cmd_src_b = 4'($urandom);
         end
      end
      check("t3_accepts", accepts, 5);
      check("t3_ready_low", cmd_ready, 0);
      for (int i = 0; i < 10; i++) begin
         check("t4_hold", {rsp_valid, cmd_ready, rsp_overflow, rsp_zero, rsp_result}, {1'b1, 1'b0, exp_q[0]});
         step();
      end
      rsp_ready = 1'b1;
      step();
      n = 0;
      for (int i = 0; i < 10 && !rsp_valid; i++) begin
         n++;
         step();
      end
      check("t4_gap", n, 2);
      drain();
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         acc = cmd_valid && cmd_ready;
         rsp_ready = ($urandom % 4) != 0;
         step();
         if (acc || !cmd_valid) begin
            cmd_valid = $urandom % 2 == 1;
            cmd_opcode = 3'($urandom); cmd_src_a = 4'($urandom); cmd_src_b = 4'($urandom);
         end
      end
      drain();
      check("rand_ovf_count", ovf_count, model_ovf);
      // saturation
      for (int i = 0; i < 256; i++) send(3'd4, 4'd7, 4'd1);
      drain();
      check("t5_sat_model", ovf_count, model_ovf);
      check("t5_sat_255", ovf_count, 255);
      send(3'd4, 4'd7, 4'd1);
      step(); step();
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      model_ovf = 0;
      check("t5_clr_capture", {rsp_valid, rsp_overflow}, 2'b11);
      check("t5_clr_prio", ovf_count, 0);
      drain();
      check("t5_clr_hold", ovf_count, 0);
      // reset while waiting on the ALU
      send(3'd4, 4'd2, 4'd3);
      step();
      reset = 1'b0;
      #1;
      exp_q.delete();
      model_ovf = 0;
      check("t6_rst_async", {rsp_valid, alu_opcode, busy, cmd_ready}, {1'b0, 3'b000, 1'b0, 1'b1});
      step(); step();
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         n += int'(rsp_valid);
         step();
      end
      check("t6_no_rsp", n, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
